// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between the
// IF stage (fetch) and the MEM stage (load/store), with pipeline stalls.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req, if_addr                fetch request and PC
//   if_rdata, if_done, if_stall    fetched word, done pulse, IF hold
//   flush                          branch taken: kills the pending fetch
//   data_rd, data_wr, data_addr,
//   data_wdata                     MEM stage load/store request
//   data_rdata, data_done,
//   data_stall                     load data, done pulse, pipeline freeze
//   mem_en, mem_we, mem_addr,
//   mem_wdata                      registered memory request
//   mem_rdata, mem_ready           memory read data and completion
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              flush,
  input  logic              data_rd,
  input  logic              data_wr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_done,
  output logic              data_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    D_RESP,
    FETCH,
    F_DROP,
    F_RESP
  } state_t;

  state_t state;
  logic   if_done_q;
  logic   data_req;

  assign data_req = data_rd | data_wr;

  // A flush landing on the response cycle still suppresses the pulse.
  assign if_done = if_done_q & ~flush;

  assign data_stall = data_req & ~data_done;

  assign if_stall = (if_req & ~if_done) | data_req
                  | (state == DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      data_rdata <= '0;
      if_done_q  <= 1'b0;
      data_done  <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      data_done <= 1'b0;
      case (state)
        IDLE: begin
          // Data first: it belongs to the older instruction.
          if (data_req) begin
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
            mem_we    <= data_wr;
            mem_en    <= 1'b1;
            state     <= DATA;
          end else if (if_req && !flush) begin
            mem_addr <= if_addr;
            mem_we   <= 1'b0;
            mem_en   <= 1'b1;
            state    <= FETCH;
          end
        end
        DATA: begin
          if (mem_ready) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            if (!mem_we) data_rdata <= mem_rdata;
            data_done <= 1'b1;
            state     <= D_RESP;
          end
        end
        // Request is still asserted here; never reissue it.
        D_RESP: state <= IDLE;
        FETCH: begin
          if (mem_ready) begin
            mem_en <= 1'b0;
            if (flush) begin
              state <= IDLE;
            end else begin
              if_rdata  <= mem_rdata;
              if_done_q <= 1'b1;
              state     <= F_RESP;
            end
          end else if (flush) begin
            state <= F_DROP;
          end
        end
        // Memory cannot abort: finish the access, throw the data away.
        F_DROP: begin
          if (mem_ready) begin
            mem_en <= 1'b0;
            state  <= IDLE;
          end
        end
        F_RESP:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a variable-latency
// memory model and directed access scenarios.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        flush;
  logic        data_rd;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        data_stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .flush(flush),
    .data_rd(data_rd), .data_wr(data_wr),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_done(data_done),
    .data_stall(data_stall),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: ready on the lat-th cycle mem_en is high.
  int lat = 1;
  int cnt = 0;
  assign mem_ready = mem_en && (cnt == lat - 1);

  always @(posedge clk) begin
    if (rst || !mem_en || mem_ready) cnt <= 0;
    else cnt <= cnt + 1;
  end

  always_comb begin
    mem_rdata = {~mem_addr[15:0], mem_addr[15:0]};
    if (mem_addr == 32'h100) mem_rdata = 32'hDEADBEEF;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iss_t;

  iss_t        iq[$];
  logic [31:0] ifq[$];
  logic [31:0] dq[$];
  logic        issued = 1'b0;

  // Monitor: memory-side request order and contents.
  always @(negedge clk) begin
    if (!rst && mem_en && !issued) begin
      issued = 1'b1;
      if (iq.size() == 0) begin
        check("unexpected_issue", mem_addr, 32'hFFFF_FFFF);
      end else begin
        iss_t e;
        e = iq.pop_front();
        check("issue_we", {31'd0, mem_we}, {31'd0, e.we});
        check("issue_addr", mem_addr, e.addr);
        if (e.we) check("issue_wdata", mem_wdata, e.wdata);
      end
    end
    if (!mem_en || mem_ready) issued = 1'b0;
  end

  // Monitor: responses to the pipeline.
  always @(negedge clk) begin
    if (!rst && if_done) begin
      if (ifq.size() == 0) check("unexpected_if_done", if_rdata, 32'hFFFF_FFFF);
      else check("if_rdata", if_rdata, ifq.pop_front());
    end
    if (!rst && data_done) begin
      if (dq.size() == 0) check("unexpected_data_done", data_rdata, 32'hFFFF_FFFF);
      else check("data_rdata", data_rdata, dq.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_if(input string nm);
    bit got = 0;
    for (int i = 0; i < 30; i++) begin
      if (if_done) begin
        got = 1;
        break;
      end
      step();
    end
    check(nm, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_data(input string nm);
    bit got = 0;
    for (int i = 0; i < 30; i++) begin
      if (data_done) begin
        got = 1;
        break;
      end
      step();
    end
    check(nm, {31'd0, got}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    flush = 1'b0;
    data_rd = 1'b0;
    data_wr = 1'b0;
    data_addr = '0;
    data_wdata = '0;
    step();
    step();
    rst = 1'b0;

    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_data_done", {31'd0, data_done}, 32'd0);
    check("rst_data_rdata", data_rdata, 32'd0);

    // 1: load, latency 1
    lat = 1;
    data_rd = 1'b1;
    data_addr = 32'h100;
    iq.push_back('{1'b0, 32'h100, 32'h0});
    dq.push_back(32'hDEADBEEF);
    #1;
    check("t1_stall_t", {31'd0, data_stall}, 32'd1);
    step();
    check("t1_en_t1", {31'd0, mem_en}, 32'd1);
    check("t1_stall_t1", {31'd0, data_stall}, 32'd1);
    check("t1_done_t1", {31'd0, data_done}, 32'd0);
    step();
    check("t1_en_t2", {31'd0, mem_en}, 32'd0);
    check("t1_done_t2", {31'd0, data_done}, 32'd1);
    check("t1_stall_t2", {31'd0, data_stall}, 32'd0);
    data_rd = 1'b0;
    step();

    // 2: store and fetch together, latency 3
    lat = 3;
    if_req = 1'b1;
    if_addr = 32'h40;
    data_wr = 1'b1;
    data_addr = 32'h200;
    data_wdata = 32'h12345678;
    iq.push_back('{1'b1, 32'h200, 32'h12345678});
    iq.push_back('{1'b0, 32'h40, 32'h0});
    dq.push_back(32'hDEADBEEF);
    ifq.push_back(32'hFFBF0040);
    begin
      bit got = 0;
      for (int i = 0; i < 30; i++) begin
        #1;
        if (if_done) begin
          got = 1;
          break;
        end
        check("t2_if_stall", {31'd0, if_stall}, 32'd1);
        if (data_done) data_wr = 1'b0;
        step();
      end
      check("t2_if_done_seen", {31'd0, got}, 32'd1);
    end
    check("t2_stall_at_done", {31'd0, if_stall}, 32'd0);
    if_req = 1'b0;
    step();

    // 3: flush in cycle 2 of a latency-4 fetch
    lat = 4;
    if_req = 1'b1;
    if_addr = 32'h70;
    iq.push_back('{1'b0, 32'h70, 32'h0});
    step();
    check("t3_en_c1", {31'd0, mem_en}, 32'd1);
    step();
    flush = 1'b1;
    if_req = 1'b0;
    step();
    flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t3_drop_en", {31'd0, mem_en}, 32'd1);
      check("t3_drop_done", {31'd0, if_done}, 32'd0);
      if (mem_ready) break;
      step();
    end
    step();
    check("t3_en_after", {31'd0, mem_en}, 32'd0);
    check("t3_done_after", {31'd0, if_done}, 32'd0);
    lat = 1;
    if_req = 1'b1;
    if_addr = 32'h80;
    iq.push_back('{1'b0, 32'h80, 32'h0});
    ifq.push_back(32'hFF7F0080);
    wait_if("t3_refetch");
    if_req = 1'b0;
    step();

    // 4: flush on the response cycle
    lat = 2;
    if_req = 1'b1;
    if_addr = 32'h90;
    iq.push_back('{1'b0, 32'h90, 32'h0});
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_en && mem_ready) break;
    end
    step();
    flush = 1'b1;
    if_req = 1'b0;
    #1;
    check("t4_done_gated", {31'd0, if_done}, 32'd0);
    step();
    flush = 1'b0;
    check("t4_idle_en", {31'd0, mem_en}, 32'd0);
    step();

    // 5: reset in the middle of a load
    lat = 5;
    data_rd = 1'b1;
    data_addr = 32'h300;
    iq.push_back('{1'b0, 32'h300, 32'h0});
    step();
    step();
    check("t5_en_before", {31'd0, mem_en}, 32'd1);
    rst = 1'b1;
    data_rd = 1'b0;
    step();
    rst = 1'b0;
    check("t5_mem_en", {31'd0, mem_en}, 32'd0);
    check("t5_mem_we", {31'd0, mem_we}, 32'd0);
    check("t5_mem_addr", mem_addr, 32'd0);
    check("t5_mem_wdata", mem_wdata, 32'd0);
    check("t5_if_rdata", if_rdata, 32'd0);
    check("t5_data_rdata", data_rdata, 32'd0);
    check("t5_data_done", {31'd0, data_done}, 32'd0);
    check("t5_if_done", {31'd0, if_done}, 32'd0);
    lat = 1;
    data_rd = 1'b1;
    data_addr = 32'h104;
    iq.push_back('{1'b0, 32'h104, 32'h0});
    dq.push_back(32'hFEFB0104);
    wait_data("t5_reload");
    data_rd = 1'b0;
    step();

    // 6: back-to-back fetches, latency 1
    lat = 1;
    if_req = 1'b1;
    if_addr = 32'h0;
    iq.push_back('{1'b0, 32'h0, 32'h0});
    iq.push_back('{1'b0, 32'h4, 32'h0});
    iq.push_back('{1'b0, 32'h8, 32'h0});
    ifq.push_back(32'hFFFF0000);
    ifq.push_back(32'hFFFB0004);
    ifq.push_back(32'hFFF70008);
    begin
      int last = 0;
      int k = 0;
      for (int i = 0; i < 40; i++) begin
        if (if_done) begin
          if (k > 0) check("t6_gap", cyc - last, 32'd3);
          last = cyc;
          k++;
          if (k == 3) begin
            if_req = 1'b0;
            break;
          end
          if_addr = k * 4;
        end
        step();
      end
      check("t6_count", k, 32'd3);
    end
    step();
    step();

    check("iq_empty", iq.size(), 32'd0);
    check("ifq_empty", ifq.size(), 32'd0);
    check("dq_empty", dq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
